qpu_itcm_arbiter: RTL and testbench

- Shares the single ITCM ICB slave port (ITCM controller) between two masters:
  - the IFU fetch port, which is read-only;
  - the external program-loader/debug port, which can read and write and is used to load quantum programs into ITCM.
- Allows one outstanding transaction at a time.
- Arbitration is round-robin, with a loader lock that fences off IFU fetches while a program is being written.
- Sits between QPU_ifu and QPU_itcm_ctrl.

---
 rtl/qpu_itcm_arbiter.sv | 127 ++++++++++++
 tb/tb_qpu_itcm_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_itcm_arbiter.sv
// qpu_itcm_arbiter
// ----------------
// Shares the single ITCM ICB slave port between the IFU fetch master
// (read-only) and the external program-loader/debug master (read/write).
// Only one transaction is in flight at a time. Arbitration is round-robin.
// The loader can raise ext_lock so that no new IFU grants are made while it
// writes a program image into ITCM.
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   ifu_cmd_* / ifu_rsp_* IFU fetch port (read-only ICB master side)
//   ext_cmd_* / ext_rsp_* loader port (read/write ICB master side)
//   ext_lock              blocks new IFU grants (sampled only when idle)
//   itcm_cmd_* / itcm_rsp_* ICB link to the ITCM controller
//   arb_busy              a transaction is being arbitrated/issued/answered
//   grant_ext             current or last owner: 1 = loader, 0 = IFU
module qpu_itcm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 64,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_cmd_valid,
    output logic          ifu_cmd_ready,
    input  logic [AW-1:0] ifu_cmd_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,

    input  logic          ext_cmd_valid,
    output logic          ext_cmd_ready,
    input  logic [AW-1:0] ext_cmd_addr,
    input  logic          ext_cmd_read,
    input  logic [DW-1:0] ext_cmd_wdata,
    input  logic [MW-1:0] ext_cmd_wmask,
    output logic          ext_rsp_valid,
    input  logic          ext_rsp_ready,
    output logic [DW-1:0] ext_rsp_rdata,

    input  logic          ext_lock,

    output logic          itcm_cmd_valid,
    input  logic          itcm_cmd_ready,
    output logic [AW-1:0] itcm_cmd_addr,
    output logic          itcm_cmd_read,
    output logic [DW-1:0] itcm_cmd_wdata,
    output logic [MW-1:0] itcm_cmd_wmask,
    input  logic          itcm_rsp_valid,
    output logic          itcm_rsp_ready,
    input  logic [DW-1:0] itcm_rsp_rdata,

    output logic          arb_busy,
    output logic          grant_ext
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    logic [1:0] state;
    logic       ifu_elig;
    logic       ext_elig;
    logic       pick_ext;
    logic       in_cmd;
    logic       in_rsp;

    // ext_lock only masks the IFU at arbitration time; an IFU transaction
    // already past IDLE is allowed to finish.
    assign ifu_elig = ifu_cmd_valid && !ext_lock;
    assign ext_elig = ext_cmd_valid;

    // On a tie the master that did not own the port last time wins.
    assign pick_ext = ext_elig && (!ifu_elig || !grant_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_ext <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_elig || ext_elig) begin
                        grant_ext <= pick_ext;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (itcm_cmd_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (itcm_rsp_valid && itcm_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_cmd   = (state == CMD);
    assign in_rsp   = (state == RSP);
    assign arb_busy = (state != IDLE);

    // Command path: payload is forwarded only while issuing, zero otherwise.
    // IFU fetches are always full-width reads.
    assign itcm_cmd_valid = in_cmd;
    assign itcm_cmd_addr  = !in_cmd ? '0 : (grant_ext ? ext_cmd_addr : ifu_cmd_addr);
    assign itcm_cmd_read  = in_cmd && (grant_ext ? ext_cmd_read : 1'b1);
    assign itcm_cmd_wdata = (in_cmd && grant_ext) ? ext_cmd_wdata : '0;
    assign itcm_cmd_wmask = !in_cmd ? '0 : (grant_ext ? ext_cmd_wmask : {MW{1'b1}});

    assign ifu_cmd_ready  = in_cmd && !grant_ext && itcm_cmd_ready;
    assign ext_cmd_ready  = in_cmd &&  grant_ext && itcm_cmd_ready;

    // Response path: a response arriving outside RSP is never acknowledged.
    assign itcm_rsp_ready = in_rsp && (grant_ext ? ext_rsp_ready : ifu_rsp_ready);

    assign ifu_rsp_valid  = in_rsp && !grant_ext && itcm_rsp_valid;
    assign ext_rsp_valid  = in_rsp &&  grant_ext && itcm_rsp_valid;
    assign ifu_rsp_rdata  = (in_rsp && !grant_ext) ? itcm_rsp_rdata : '0;
    assign ext_rsp_rdata  = (in_rsp &&  grant_ext) ? itcm_rsp_rdata : '0;

endmodule

// File: tb/tb_qpu_itcm_arbiter.sv
module tb_qpu_itcm_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clk;
    logic          rst;
    logic          ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0] ifu_cmd_addr;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          ext_cmd_valid, ext_cmd_ready, ext_cmd_read, ext_rsp_valid, ext_rsp_ready;
    logic [AW-1:0] ext_cmd_addr;
    logic [DW-1:0] ext_cmd_wdata, ext_rsp_rdata;
    logic [MW-1:0] ext_cmd_wmask;
    logic          ext_lock;
    logic          itcm_cmd_valid, itcm_cmd_ready, itcm_cmd_read;
    logic [AW-1:0] itcm_cmd_addr;
    logic [DW-1:0] itcm_cmd_wdata, itcm_rsp_rdata;
    logic [MW-1:0] itcm_cmd_wmask;
    logic          itcm_rsp_valid, itcm_rsp_ready;
    logic          arb_busy, grant_ext;

    qpu_itcm_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk(clk), .rst(rst),
        .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
        .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_addr(ext_cmd_addr),
        .ext_cmd_read(ext_cmd_read), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
        .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
        .ext_lock(ext_lock),
        .itcm_cmd_valid(itcm_cmd_valid), .itcm_cmd_ready(itcm_cmd_ready), .itcm_cmd_addr(itcm_cmd_addr),
        .itcm_cmd_read(itcm_cmd_read), .itcm_cmd_wdata(itcm_cmd_wdata), .itcm_cmd_wmask(itcm_cmd_wmask),
        .itcm_rsp_valid(itcm_rsp_valid), .itcm_rsp_ready(itcm_rsp_ready), .itcm_rsp_rdata(itcm_rsp_rdata),
        .arb_busy(arb_busy), .grant_ext(grant_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Stimulus knobs (percent probabilities)
    int unsigned p_ifu, p_ext, p_cready, p_rvalid, p_rready;
    bit fix_ifu, fix_ext, fix_rd, rnd_lock;

    // Environment state: masters hold requests, slave owes at most one response
    bit          ifu_pend, ext_pend, slv_have, rsp_clr;
    logic [63:0] slv_rdata;

    // Transaction-level reference: who owns the port (0 none, 1 IFU, 2 loader),
    // whether its command has been taken by ITCM, and who owned it last.
    int m_owner;
    bit m_issued;
    bit m_last_ext;

    // Observations for directed expectations
    int          cyc, t_start, t_end;
    int          g_hist[8];
    int          n_grant, n_grant_ifu;
    int          n_ifu_rsp, n_ext_rspv, n_ifu_cr, n_ext_cr, n_cmdv, n_idle, n_rstall, n_addr_bad;
    logic [63:0] cap_ifu_rdata, cap_ifu_wmask, cap_ifu_read;
    logic [63:0] cap_ext_addr, cap_ext_wdata, cap_ext_wmask, cap_ext_read;

    task automatic clr_caps();
        for (int i = 0; i < 8; i++) g_hist[i] = -1;
        n_grant = 0; n_grant_ifu = 0; n_ifu_rsp = 0; n_ext_rspv = 0; n_ifu_cr = 0;
        n_ext_cr = 0; n_cmdv = 0; n_idle = 0; n_rstall = 0; n_addr_bad = 0;
        t_start = -1; t_end = -1;
        cap_ifu_rdata = '0; cap_ifu_wmask = '0; cap_ifu_read = '0;
        cap_ext_addr = '0; cap_ext_wdata = '0; cap_ext_wmask = '0; cap_ext_read = '1;
    endtask

    task automatic clr_env();
        ifu_pend = 0; ext_pend = 0; slv_have = 0; rsp_clr = 0; slv_rdata = '0;
        ifu_cmd_valid = 0; ifu_cmd_addr = '0; ifu_rsp_ready = 0;
        ext_cmd_valid = 0; ext_cmd_addr = '0; ext_cmd_read = 0; ext_cmd_wdata = '0;
        ext_cmd_wmask = '0; ext_rsp_ready = 0; ext_lock = 0;
        itcm_cmd_ready = 0; itcm_rsp_valid = 0; itcm_rsp_rdata = '0;
        m_owner = 0; m_issued = 0; m_last_ext = 1;
    endtask

    task automatic set_knobs(input int unsigned pi, input int unsigned pe, input int unsigned pc,
                             input int unsigned pv, input int unsigned pr);
        p_ifu = pi; p_ext = pe; p_cready = pc; p_rvalid = pv; p_rready = pr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_env();
        clr_caps();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at the falling edge, check, then book the handshakes
    // that the next rising edge will perform.
    task automatic cycle();
        logic        e_cmdv, e_ifu_cr, e_ext_cr, e_rr, e_ifu_rv, e_ext_rv, ie, ee;
        logic [63:0] e_addr, e_wdata, e_wmask, e_read, e_ifu_rd, e_ext_rd;

        if (!ifu_pend && ($urandom_range(99) < p_ifu)) begin
            ifu_pend = 1;
            ifu_cmd_addr = fix_ifu ? 16'h0010 : 16'($urandom);
            if (t_start < 0) t_start = cyc;
        end
        ifu_cmd_valid = ifu_pend;
        if (!ext_pend && ($urandom_range(99) < p_ext)) begin
            ext_pend = 1;
            if (fix_ext) begin
                ext_cmd_addr = 16'h0020; ext_cmd_read = 0;
                ext_cmd_wdata = 64'hDEADBEEF; ext_cmd_wmask = 8'h0F;
            end else begin
                ext_cmd_addr = 16'($urandom); ext_cmd_read = 1'($urandom);
                ext_cmd_wdata = {$urandom, $urandom}; ext_cmd_wmask = 8'($urandom);
            end
        end
        ext_cmd_valid  = ext_pend;
        itcm_cmd_ready = ($urandom_range(99) < p_cready);
        if (rsp_clr) begin
            itcm_rsp_valid = 0;
            rsp_clr = 0;
        end
        if (slv_have && !itcm_rsp_valid && ($urandom_range(99) < p_rvalid)) begin
            itcm_rsp_valid = 1;
            itcm_rsp_rdata = slv_rdata;
        end
        ifu_rsp_ready = ($urandom_range(99) < p_rready);
        ext_rsp_ready = ($urandom_range(99) < p_rready);
        if (rnd_lock && ($urandom_range(99) < 5)) ext_lock = !ext_lock;
        #1;

        e_cmdv   = (m_owner != 0) && !m_issued;
        e_addr   = !e_cmdv ? 64'd0 : (m_owner == 1 ? 64'(ifu_cmd_addr) : 64'(ext_cmd_addr));
        e_read   = !e_cmdv ? 64'd0 : (m_owner == 1 ? 64'd1 : 64'(ext_cmd_read));
        e_wdata  = (e_cmdv && m_owner == 2) ? ext_cmd_wdata : 64'd0;
        e_wmask  = !e_cmdv ? 64'd0 : (m_owner == 1 ? 64'hFF : 64'(ext_cmd_wmask));
        e_ifu_cr = e_cmdv && (m_owner == 1) && itcm_cmd_ready;
        e_ext_cr = e_cmdv && (m_owner == 2) && itcm_cmd_ready;
        e_rr     = m_issued && (m_owner == 1 ? ifu_rsp_ready : ext_rsp_ready);
        e_ifu_rv = m_issued && (m_owner == 1) && itcm_rsp_valid;
        e_ext_rv = m_issued && (m_owner == 2) && itcm_rsp_valid;
        e_ifu_rd = (m_issued && m_owner == 1) ? itcm_rsp_rdata : 64'd0;
        e_ext_rd = (m_issued && m_owner == 2) ? itcm_rsp_rdata : 64'd0;

        chk("arb_busy",       64'(arb_busy),       64'(m_owner != 0));
        chk("grant_ext",      64'(grant_ext),      64'(m_last_ext));
        chk("itcm_cmd_valid", 64'(itcm_cmd_valid), 64'(e_cmdv));
        chk("itcm_cmd_addr",  64'(itcm_cmd_addr),  e_addr);
        chk("itcm_cmd_read",  64'(itcm_cmd_read),  e_read);
        chk("itcm_cmd_wdata", itcm_cmd_wdata,      e_wdata);
        chk("itcm_cmd_wmask", 64'(itcm_cmd_wmask), e_wmask);
        chk("ifu_cmd_ready",  64'(ifu_cmd_ready),  64'(e_ifu_cr));
        chk("ext_cmd_ready",  64'(ext_cmd_ready),  64'(e_ext_cr));
        chk("itcm_rsp_ready", 64'(itcm_rsp_ready), 64'(e_rr));
        chk("ifu_rsp_valid",  64'(ifu_rsp_valid),  64'(e_ifu_rv));
        chk("ext_rsp_valid",  64'(ext_rsp_valid),  64'(e_ext_rv));
        chk("ifu_rsp_rdata",  ifu_rsp_rdata,       e_ifu_rd);
        chk("ext_rsp_rdata",  ext_rsp_rdata,       e_ext_rd);

        // Observations taken from the DUT for the directed scenarios
        if (itcm_cmd_valid) n_cmdv++;
        if (itcm_cmd_valid && itcm_cmd_addr != 16'h0010) n_addr_bad++;
        if (!arb_busy) n_idle++;
        if (ifu_cmd_ready) n_ifu_cr++;
        if (ext_cmd_ready) n_ext_cr++;
        if (ext_rsp_valid) n_ext_rspv++;
        if (ifu_rsp_valid && !ifu_rsp_ready) n_rstall++;
        if (itcm_cmd_valid && itcm_cmd_ready) begin
            if (n_grant < 8) g_hist[n_grant] = int'(grant_ext);
            n_grant++;
            if (!grant_ext) begin
                n_grant_ifu++;
                cap_ifu_read = 64'(itcm_cmd_read); cap_ifu_wmask = 64'(itcm_cmd_wmask);
            end else begin
                cap_ext_addr = 64'(itcm_cmd_addr); cap_ext_wdata = itcm_cmd_wdata;
                cap_ext_wmask = 64'(itcm_cmd_wmask); cap_ext_read = 64'(itcm_cmd_read);
            end
        end
        if (ifu_rsp_valid && ifu_rsp_ready) begin
            n_ifu_rsp++;
            cap_ifu_rdata = ifu_rsp_rdata;
            if (t_end < 0) t_end = cyc;
        end

        // Environment bookkeeping from the reference's view of the handshakes
        if (e_ifu_cr) ifu_pend = 0;
        if (e_ext_cr) ext_pend = 0;
        if (e_cmdv && itcm_cmd_ready) begin
            slv_have  = 1;
            slv_rdata = fix_rd ? 64'h1122334455667788 : {$urandom, $urandom};
        end
        if (itcm_rsp_valid && e_rr) begin
            slv_have = 0;
            rsp_clr  = 1;
        end

        // Reference advance
        if (m_owner == 0) begin
            ie = ifu_cmd_valid && !ext_lock;
            ee = ext_cmd_valid;
            if (ie && ee)  m_owner = m_last_ext ? 1 : 2;
            else if (ee)   m_owner = 2;
            else if (ie)   m_owner = 1;
            if (m_owner != 0) m_last_ext = (m_owner == 2);
        end else if (!m_issued) begin
            if (itcm_cmd_ready) m_issued = 1;
        end else if (itcm_rsp_valid && e_rr) begin
            m_owner  = 0;
            m_issued = 0;
        end

        cyc++;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        fix_ifu = 0; fix_ext = 0; fix_rd = 0; rnd_lock = 0;
        set_knobs(0, 0, 100, 100, 100);
        rst = 1'b1;
        clr_env();
        clr_caps();
        #3;
        chk("rst_busy",      64'(arb_busy),       64'd0);
        chk("rst_grant_ext", 64'(grant_ext),      64'd1);
        chk("rst_cmd_valid", 64'(itcm_cmd_valid), 64'd0);
        chk("rst_cmd_read",  64'(itcm_cmd_read),  64'd0);
        chk("rst_cmd_wmask", 64'(itcm_cmd_wmask), 64'd0);
        chk("rst_rsp_ready", 64'(itcm_rsp_ready), 64'd0);
        @(negedge clk);
        do_reset();

        // IFU-only fetch with zero-wait ITCM
        fix_ifu = 1; fix_rd = 1;
        set_knobs(100, 0, 100, 100, 100);
        cycle();
        p_ifu = 0;
        repeat (4) cycle();
        chk("t1_cmd_read",   cap_ifu_read,  64'd1);
        chk("t1_cmd_wmask",  cap_ifu_wmask, 64'hFF);
        chk("t1_rdata",      cap_ifu_rdata, 64'h1122334455667788);
        chk("t1_ext_rspv",   64'(n_ext_rspv), 64'd0);
        chk("t1_n_rsp",      64'(n_ifu_rsp),  64'd1);
        chk("t1_duration",   64'(t_end - t_start + 1), 64'd3);

        // Both masters requesting continuously: strict alternation
        do_reset();
        fix_ext = 1; fix_rd = 0;
        set_knobs(100, 100, 100, 100, 100);
        repeat (13) cycle();
        for (int i = 0; i < 4; i++) chk("t2_grant_order", 64'(g_hist[i]), 64'(i % 2));
        chk("t2_ext_addr",  cap_ext_addr,  64'h0020);
        chk("t2_ext_wdata", cap_ext_wdata, 64'hDEADBEEF);
        chk("t2_ext_wmask", cap_ext_wmask, 64'h0F);
        chk("t2_ext_read",  cap_ext_read,  64'd0);

        // Loader lock fences off the IFU
        do_reset();
        fix_ext = 0;
        ext_lock = 1;
        set_knobs(100, 100, 100, 100, 100);
        repeat (15) cycle();
        chk("t3_ifu_ready_seen", 64'(n_ifu_cr),    64'd0);
        chk("t3_ifu_grants",     64'(n_grant_ifu), 64'd0);
        chk("t3_ext_grants",     64'(n_grant),     64'd5);
        clr_caps();
        ext_lock = 0;
        repeat (4) cycle();
        chk("t3_unlock_grant", 64'(g_hist[0]), 64'd0);

        // Lock raised while an IFU response is pending
        do_reset();
        set_knobs(100, 0, 100, 0, 100);
        cycle();
        p_ifu = 0;
        repeat (3) cycle();
        clr_caps();
        ext_lock = 1;
        set_knobs(100, 100, 100, 100, 100);
        repeat (6) cycle();
        chk("t4_ifu_rsp_done",  64'(n_ifu_rsp), 64'd1);
        chk("t4_next_is_ext",   64'(g_hist[0]), 64'd1);
        chk("t4_ifu_ready",     64'(n_ifu_cr),  64'd0);
        ext_lock = 0;

        // Command stall then response stall
        do_reset();
        fix_ifu = 1;
        set_knobs(100, 100, 0, 100, 100);
        cycle();
        p_ifu = 0;
        clr_caps();
        repeat (5) cycle();
        chk("t5_cmd_stall",   64'(n_cmdv),     64'd5);
        chk("t5_addr_stable", 64'(n_addr_bad), 64'd0);
        set_knobs(0, 100, 100, 100, 0);
        repeat (4) cycle();
        chk("t5_rsp_stall",   64'(n_rstall), 64'd3);
        chk("t5_busy_all",    64'(n_idle),   64'd0);
        chk("t5_ext_ready",   64'(n_ext_cr), 64'd0);
        chk("t5_cmd_total",   64'(n_cmdv),   64'd6);
        p_rready = 100;
        repeat (2) cycle();
        chk("t5_rsp_done",    64'(n_ifu_rsp), 64'd1);

        // Asynchronous reset with a response pending
        do_reset();
        fix_ifu = 0;
        set_knobs(100, 0, 100, 100, 0);
        cycle();
        p_ifu = 0;
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy",      64'(arb_busy),       64'd0);
        chk("t6_grant_ext", 64'(grant_ext),      64'd1);
        chk("t6_rsp_ready", 64'(itcm_rsp_ready), 64'd0);
        chk("t6_ifu_rspv",  64'(ifu_rsp_valid),  64'd0);
        chk("t6_cmd_valid", 64'(itcm_cmd_valid), 64'd0);
        @(negedge clk);
        do_reset();
        set_knobs(100, 100, 100, 100, 100);
        repeat (4) cycle();
        chk("t6_first_tie", 64'(g_hist[0]), 64'd0);

        // Randomized traffic against the reference
        do_reset();
        rnd_lock = 1;
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100, 10),
                      $urandom_range(100, 10), $urandom_range(100, 10));
            repeat (200) cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
